move_sequencer: RTL and testbench

Sequences one 2048 move across the 4x4 board. On a direction command it walks the four board lines in order. For each line it reads four cells, slides and merges them, and writes the result back. It also reports whether anything moved, the score gained, and whether a win tile was created. It sits between the top-level game FSM (which issues start/dir and consumes done/moved/win) and the board storage (which serves line-ordered reads and writes).

---
 rtl/move_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// ---------------------------------------------------------------------------
// move_sequencer
//
// Purpose:
//    Sequences one 2048 move across the 4x4 board. A direction command walks
//    the four board lines in order 0..3. For each line the block reads four
//    cells, slides and merges them toward element 0, and writes the result
//    back. It reports whether anything moved, the score gained, and whether a
//    win tile was created. Every move takes exactly 13 cycles after start is
//    accepted (READ/MERGE/WRITE per line, then one DONE cycle).
//
// Ports:
//    clk_i          system clock, everything on the rising edge
//    reset_i        synchronous, active-high reset
//    start_i        request a move, sampled only in IDLE
//    dir_i          00 up, 01 down, 10 left, 11 right; captured with start_i
//    busy_o         high from the cycle after acceptance through DONE
//    done_o         one-cycle pulse in DONE
//    moved_o        any line changed during the last move
//    win_o          a merge produced exponent >= WIN_EXP during the last move
//    score_delta_o  saturating sum of 2^(merged exponent) over the last move
//    line_rd_en_o   read strobe toward board storage
//    line_wr_en_o   write strobe toward board storage
//    line_idx_o     line number 0..3 (row for left/right, column for up/down)
//    line_dir_o     captured direction, drives board address mapping
//    line_rdata_i   cells of the line, element 0 in [CELL_W-1:0]
//    line_wdata_o   merged line, same ordering
// ---------------------------------------------------------------------------
module move_sequencer #(
   parameter int CELL_W  = 4,
   parameter int WIN_EXP = 11,
   parameter int SCORE_W = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [1:0]            dir_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  moved_o,
   output logic                  win_o,
   output logic [SCORE_W-1:0]    score_delta_o,
   output logic                  line_rd_en_o,
   output logic                  line_wr_en_o,
   output logic [1:0]            line_idx_o,
   output logic [1:0]            line_dir_o,
   input  logic [4*CELL_W-1:0]   line_rdata_i,
   output logic [4*CELL_W-1:0]   line_wdata_o
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      MERGE,
      WRITE,
      DONE
   } state_t;

   // The largest exponent a cell can hold; such cells never merge so that the
   // incremented exponent can never wrap.
   localparam logic [CELL_W-1:0]  EXP_MAX   = {CELL_W{1'b1}};
   // Score arithmetic runs two bits wider than the output so that the sum of
   // two already-saturated terms cannot wrap before it is clamped.
   localparam logic [SCORE_W+1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};
   localparam logic [SCORE_W+1:0] ONE_W     = {{(SCORE_W+1){1'b0}}, 1'b1};

   state_t                 state_q;
   logic [1:0]             dir_q;
   logic [1:0]             idx_q;
   logic [4*CELL_W-1:0]    lineIn_q;
   logic [4*CELL_W-1:0]    wdata_q;
   logic [SCORE_W-1:0]     lineScore_q;
   logic                   lineWin_q;
   logic                   moved_q;
   logic                   win_q;
   logic [SCORE_W-1:0]     score_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   rdEn_q;
   logic                   wrEn_q;

   logic [4*CELL_W-1:0]    mergeLine_d;
   logic [SCORE_W-1:0]     mergeScore_d;
   logic                   mergeWin_d;
   logic [SCORE_W-1:0]     score_d;

   // Slide-and-merge of the registered input line. First the non-empty cells
   // are compacted toward element 0 keeping their order, then pairs are
   // scanned from element 0 upward: an equal pair becomes one cell of e+1 and
   // both source cells are consumed, so no tile merges twice. Writes to a
   // running output slot are done by comparing against constant loop indices
   // so the slot counter never needs to index an array directly. The score
   // term is clamped before summing, which is equivalent to evaluating the
   // shift at full width and then saturating.
   always_comb begin : mergeLogic
      logic [CELL_W-1:0]   cellIn [4];
      logic [CELL_W-1:0]   comp [5];
      logic [CELL_W:0]     ePlus;
      logic [SCORE_W+1:0]  term;
      logic [SCORE_W+1:0]  sum;
      int                  pos;
      logic                skip;

      mergeLine_d  = '0;
      mergeScore_d = '0;
      mergeWin_d   = 1'b0;
      ePlus        = '0;
      term         = '0;
      sum          = '0;
      pos          = 0;
      skip         = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cellIn[i] = lineIn_q[i*CELL_W +: CELL_W];
      end
      for (int i = 0; i < 5; i++) begin
         comp[i] = '0;
      end

      for (int i = 0; i < 4; i++) begin
         if (cellIn[i] != '0) begin
            for (int j = 0; j < 4; j++) begin
               if (j == pos) begin
                  comp[j] = cellIn[i];
               end
            end
            pos = pos + 1;
         end
      end

      pos = 0;
      for (int i = 0; i < 4; i++) begin
         ePlus = {1'b0, comp[i]} + {{CELL_W{1'b0}}, 1'b1};
         if (skip) begin
            skip = 1'b0;
         end else if (comp[i] != '0) begin
            if ((comp[i] == comp[i+1]) && (comp[i] != EXP_MAX)) begin
               term = (int'(ePlus) >= SCORE_W) ? SCORE_MAX : (ONE_W << ePlus);
               sum  = sum + term;
               if (int'(ePlus) >= WIN_EXP) begin
                  mergeWin_d = 1'b1;
               end
               for (int j = 0; j < 4; j++) begin
                  if (j == pos) begin
                     mergeLine_d[j*CELL_W +: CELL_W] = ePlus[CELL_W-1:0];
                  end
               end
               skip = 1'b1;
            end else begin
               for (int j = 0; j < 4; j++) begin
                  if (j == pos) begin
                     mergeLine_d[j*CELL_W +: CELL_W] = comp[i];
                  end
               end
            end
            pos = pos + 1;
         end
      end

      mergeScore_d = (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   end

   // Saturating accumulation of the per-line score into the move total.
   always_comb begin : scoreAccum
      logic [SCORE_W+1:0] total;
      total   = {2'b00, score_q} + {2'b00, lineScore_q};
      score_d = (total > SCORE_MAX) ? {SCORE_W{1'b1}} : total[SCORE_W-1:0];
   end

   // Move sequencer. All outputs are registered: the strobes are raised on
   // the edge that enters READ or WRITE so they line up exactly with those
   // states, and done is raised on the edge that enters DONE. The move
   // results (moved/win/score) fold in each line on leaving WRITE and then
   // hold until the next accepted start. Start is only looked at in IDLE, so
   // requests during a move, including the DONE cycle, are dropped.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         dir_q       <= '0;
         idx_q       <= '0;
         lineIn_q    <= '0;
         wdata_q     <= '0;
         lineScore_q <= '0;
         lineWin_q   <= 1'b0;
         moved_q     <= 1'b0;
         win_q       <= 1'b0;
         score_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rdEn_q      <= 1'b0;
         wrEn_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         rdEn_q <= 1'b0;
         wrEn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  dir_q   <= dir_i;
                  moved_q <= 1'b0;
                  win_q   <= 1'b0;
                  score_q <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  rdEn_q  <= 1'b1;
                  state_q <= READ;
               end
            end
            READ: begin
               lineIn_q <= line_rdata_i;
               state_q  <= MERGE;
            end
            MERGE: begin
               wdata_q     <= mergeLine_d;
               lineScore_q <= mergeScore_d;
               lineWin_q   <= mergeWin_d;
               wrEn_q      <= 1'b1;
               state_q     <= WRITE;
            end
            WRITE: begin
               moved_q <= moved_q | (wdata_q != lineIn_q);
               win_q   <= win_q | lineWin_q;
               score_q <= score_d;
               if (idx_q == 2'd3) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  rdEn_q  <= 1'b1;
                  state_q <= READ;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign moved_o       = moved_q;
   assign win_o         = win_q;
   assign score_delta_o = score_q;
   assign line_rd_en_o  = rdEn_q;
   assign line_wr_en_o  = wrEn_q;
   assign line_idx_o    = idx_q;
   assign line_dir_o    = dir_q;
   assign line_wdata_o  = wdata_q;

endmodule

// File: tb/tb_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_sequencer
//
// Purpose:
//    Directed self-checking bench for move_sequencer. A small board model
//    serves line reads combinationally from line_idx; each move is driven,
//    its strobes, indices and written data are logged cycle by cycle, and
//    the results are compared with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_move_sequencer;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    dir;
   logic          busy;
   logic          done;
   logic          moved;
   logic          win;
   logic [15:0]   scoreDelta;
   logic          lineRdEn;
   logic          lineWrEn;
   logic [1:0]    lineIdx;
   logic [1:0]    lineDir;
   logic [15:0]   lineRdata;
   logic [15:0]   lineWdata;

   logic [15:0]   board [4];

   int            checks   = 0;
   int            failures = 0;

   logic [31:0]   busyMask;
   logic [31:0]   rdMask;
   logic [31:0]   wrMask;
   logic [7:0]    rdIdxLog;
   logic [7:0]    wrIdxLog;
   logic [15:0]   wrData [8];
   int            wrCount;
   int            doneCount;
   int            doneAt;
   int            dirErr;

   move_sequencer #(
      .CELL_W  (4),
      .WIN_EXP (11),
      .SCORE_W (16)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .dir_i         (dir),
      .busy_o        (busy),
      .done_o        (done),
      .moved_o       (moved),
      .win_o         (win),
      .score_delta_o (scoreDelta),
      .line_rd_en_o  (lineRdEn),
      .line_wr_en_o  (lineWrEn),
      .line_idx_o    (lineIdx),
      .line_dir_o    (lineDir),
      .line_rdata_i  (lineRdata),
      .line_wdata_o  (lineWdata)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Board storage answers reads combinationally for the addressed line.
   assign lineRdata = board[lineIdx];

   function automatic logic [15:0] mkLine(input int e0, input int e1, input int e2, input int e3);
      logic [15:0] v;
      v = {e3[3:0], e2[3:0], e1[3:0], e0[3:0]};
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"},  32'(busy),       32'd0);
      checkOutput({tag, "_done"},  32'(done),       32'd0);
      checkOutput({tag, "_moved"}, 32'(moved),      32'd0);
      checkOutput({tag, "_win"},   32'(win),        32'd0);
      checkOutput({tag, "_score"}, 32'(scoreDelta), 32'd0);
      checkOutput({tag, "_rd"},    32'(lineRdEn),   32'd0);
      checkOutput({tag, "_wr"},    32'(lineWrEn),   32'd0);
      checkOutput({tag, "_idx"},   32'(lineIdx),    32'd0);
      checkOutput({tag, "_dir"},   32'(lineDir),    32'd0);
      checkOutput({tag, "_wdata"}, 32'(lineWdata),  32'd0);
   endtask

   // Drives one move and logs everything seen over 20 cycles after the
   // accepting edge. Cycle n here is cycle k+n. Optional extra start pulses
   // with a flipped dir land in MERGE1 and in DONE; optional reset lands in
   // cycle k+resetAt and the reset state is checked in the following cycle.
   task automatic applyStimulus(input logic [1:0] dirV, input logic [15:0] l0, input logic [15:0] l1,
                                input logic [15:0] l2, input logic [15:0] l3,
                                input bit midStart, input int resetAt);
      board[0] = l0;
      board[1] = l1;
      board[2] = l2;
      board[3] = l3;
      busyMask = '0;
      rdMask   = '0;
      wrMask   = '0;
      rdIdxLog = '0;
      wrIdxLog = '0;
      wrCount  = 0;
      doneCount = 0;
      doneAt   = 0;
      dirErr   = 0;
      for (int i = 0; i < 8; i++) wrData[i] = '0;
      @(negedge clk);
      start = 1'b1;
      dir   = dirV;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         busyMask[n] = busy;
         if (lineRdEn) begin
            rdMask[n] = 1'b1;
            rdIdxLog  = {lineIdx, rdIdxLog[7:2]};
            if (lineDir != dirV) dirErr++;
         end
         if (lineWrEn) begin
            wrMask[n] = 1'b1;
            wrIdxLog  = {lineIdx, wrIdxLog[7:2]};
            if (lineDir != dirV) dirErr++;
            if (wrCount < 8) wrData[wrCount] = lineWdata;
            wrCount++;
         end
         if (done) begin
            doneCount++;
            doneAt = n;
         end
         if (midStart && (n == 5 || n == 13)) begin
            start = 1'b1;
            dir   = ~dirV;
         end else begin
            start = 1'b0;
         end
         if (resetAt != 0 && n == resetAt) reset = 1'b1;
         if (resetAt != 0 && n == resetAt + 1) begin
            checkResetState("midReset");
            reset = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic checkMove(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input bit expMoved, input bit expWin, input logic [15:0] expScore);
      checkOutput({tag, "_doneAt"},    32'(doneAt),    32'd13);
      checkOutput({tag, "_doneCount"}, 32'(doneCount), 32'd1);
      checkOutput({tag, "_busyMask"},  busyMask,       32'h0000_3FFE);
      checkOutput({tag, "_rdMask"},    rdMask,         32'h0000_0492);
      checkOutput({tag, "_wrMask"},    wrMask,         32'h0000_1248);
      checkOutput({tag, "_rdIdx"},     32'(rdIdxLog),  32'hE4);
      checkOutput({tag, "_wrIdx"},     32'(wrIdxLog),  32'hE4);
      checkOutput({tag, "_dirErr"},    32'(dirErr),    32'd0);
      checkOutput({tag, "_wdata0"},    32'(wrData[0]), 32'(w0));
      checkOutput({tag, "_wdata1"},    32'(wrData[1]), 32'(w1));
      checkOutput({tag, "_wdata2"},    32'(wrData[2]), 32'(w2));
      checkOutput({tag, "_wdata3"},    32'(wrData[3]), 32'(w3));
      checkOutput({tag, "_moved"},     32'(moved),      32'(expMoved));
      checkOutput({tag, "_win"},       32'(win),        32'(expWin));
      checkOutput({tag, "_score"},     32'(scoreDelta), 32'(expScore));
      checkOutput({tag, "_busyAfter"}, 32'(busy),       32'd0);
   endtask

   // Main directed sequence.
   initial begin
      reset = 1'b1;
      start = 1'b0;
      dir   = 2'b00;
      for (int i = 0; i < 4; i++) board[i] = '0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      reset = 1'b0;

      applyStimulus(2'b10, mkLine(1,1,2,2), 16'h0, 16'h0, 16'h0, 1'b0, 0);
      checkMove("leftPairs", mkLine(2,3,0,0), 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'd12);

      applyStimulus(2'b00, mkLine(1,1,1,1), 16'h0, 16'h0, 16'h0, 1'b0, 0);
      checkMove("fourEqual", mkLine(2,2,0,0), 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'd8);

      applyStimulus(2'b01, mkLine(0,1,0,1), 16'h0, 16'h0, 16'h0, 1'b0, 0);
      checkMove("gapMerge", mkLine(2,0,0,0), 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'd4);

      applyStimulus(2'b11, mkLine(1,2,3,4), mkLine(1,2,3,4), mkLine(1,2,3,4), mkLine(1,2,3,4), 1'b0, 0);
      checkMove("noMove", mkLine(1,2,3,4), mkLine(1,2,3,4), mkLine(1,2,3,4), mkLine(1,2,3,4),
                1'b0, 1'b0, 16'd0);

      applyStimulus(2'b10, 16'h0, mkLine(10,10,0,0), 16'h0, 16'h0, 1'b0, 0);
      checkMove("winMerge", 16'h0, mkLine(11,0,0,0), 16'h0, 16'h0, 1'b1, 1'b1, 16'd2048);

      applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, mkLine(15,15,0,0), 1'b0, 0);
      checkMove("maxNoMerge", 16'h0, 16'h0, 16'h0, mkLine(15,15,0,0), 1'b0, 1'b0, 16'd0);

      applyStimulus(2'b01, mkLine(2,2,2,0), 16'h0, mkLine(3,0,3,5), mkLine(2,2,3,0), 1'b1, 0);
      checkMove("midStart", mkLine(3,2,0,0), 16'h0, mkLine(4,5,0,0), mkLine(3,3,0,0),
                1'b1, 1'b0, 16'd32);

      applyStimulus(2'b10, mkLine(1,1,2,2), 16'h0, 16'h0, 16'h0, 1'b0, 5);
      checkOutput("midReset_wrMask",    wrMask,            32'h0000_0008);
      checkOutput("midReset_doneCount", 32'(doneCount),    32'd0);
      checkOutput("midReset_busyAfter", 32'(busy),         32'd0);

      applyStimulus(2'b10, mkLine(1,1,2,2), 16'h0, 16'h0, 16'h0, 1'b0, 0);
      checkMove("afterReset", mkLine(2,3,0,0), 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'd12);

      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      dir   = 2'b11;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      checkOutput("resetStart_busy", 32'(busy),     32'd0);
      checkOutput("resetStart_rd",   32'(lineRdEn), 32'd0);
      @(negedge clk);
      checkOutput("resetStart_busy2", 32'(busy),    32'd0);
      checkOutput("resetStart_dir",   32'(lineDir), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
